// File: rtl/rv32_decode_stage.sv
// RV32IM instruction decode stage: one registered output bundle with a
// valid/ready handshake on both sides, a load-use interlock and a
// saturating counter of inserted load-use bubbles.
package rv32_decode_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Branch compares carry their own ALU op so execute needs no funct3.
  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,  ALU_SUB  = 5'd1,  ALU_SLL  = 5'd2,  ALU_SLT  = 5'd3,
    ALU_SLTU  = 5'd4,  ALU_XOR  = 5'd5,  ALU_SRL  = 5'd6,  ALU_SRA  = 5'd7,
    ALU_OR    = 5'd8,  ALU_AND  = 5'd9,  ALU_PASSB = 5'd10, ALU_BEQ = 5'd11,
    ALU_BNE   = 5'd12, ALU_BLT  = 5'd13, ALU_BGE  = 5'd14, ALU_BLTU = 5'd15,
    ALU_BGEU  = 5'd16
  } alu_op_t;

  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2, WB_MEXT = 2'd3} wb_sel_t;

  typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4} imm_type_t;

  typedef enum logic [2:0] {
    MEM_BYTE = 3'd0, MEM_HALF = 3'd1, MEM_WORD = 3'd2, MEM_BYTE_U = 3'd4, MEM_HALF_U = 3'd5
  } mem_size_t;

  typedef enum logic [2:0] {
    M_MUL = 3'd0, M_MULH = 3'd1, M_MULHSU = 3'd2, M_MULHU = 3'd3,
    M_DIV = 3'd4, M_DIVU = 3'd5, M_REM = 3'd6, M_REMU = 3'd7
  } m_op_t;

endpackage

// Handshake: a word moves in when instr_valid && instr_ready and out when
// dec_valid && dec_ready; a held bundle is stable until it moves out.
// Fields not relevant to an instruction (and all fields of an illegal one)
// carry the reset encodings; rd/rs1/rs2 always carry the raw word fields.
module rv32_decode_stage
  import rv32_decode_pkg::*;
#(
  parameter int unsigned ENABLE_M       = 1,
  parameter int unsigned LOAD_USE_STALL = 1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             instr_valid,
  input  logic [XLEN-1:0]  instr,
  output logic             instr_ready,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src,
  output logic             branch_en,
  output logic             jump,
  output logic             is_jalr,
  output logic             m_valid,
  output alu_op_t          alu_op,
  output wb_sel_t          wb_sel,
  output imm_type_t        imm_type,
  output mem_size_t        mem_size,
  output m_op_t            m_op,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  logic      d_reg_write, d_mem_read, d_mem_write, d_alu_src;
  logic      d_branch_en, d_jump, d_is_jalr, d_m_valid, d_illegal;
  logic      bad;
  alu_op_t   d_alu_op;
  wb_sel_t   d_wb_sel;
  imm_type_t d_imm_type;
  mem_size_t d_mem_size;
  m_op_t     d_m_op;

  // Combinational decode of the offered word; an illegal word collapses to a
  // bundle with every control cleared and only the illegal flag set.
  always_comb begin
    d_reg_write = 1'b0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_alu_src   = 1'b0;
    d_branch_en = 1'b0;
    d_jump      = 1'b0;
    d_is_jalr   = 1'b0;
    d_m_valid   = 1'b0;
    d_illegal   = 1'b0;
    d_alu_op    = ALU_ADD;
    d_wb_sel    = WB_ALU;
    d_imm_type  = IMM_I;
    d_mem_size  = MEM_WORD;
    d_m_op      = M_MUL;
    bad         = (instr[1:0] != 2'b11);
    case (opc)
      OPC_LUI: begin
        d_reg_write = 1'b1;
        d_alu_src   = 1'b1;
        d_imm_type  = IMM_U;
        d_alu_op    = ALU_PASSB;
      end
      OPC_AUIPC: begin
        d_reg_write = 1'b1;
        d_alu_src   = 1'b1;
        d_imm_type  = IMM_U;
      end
      OPC_JAL: begin
        d_reg_write = 1'b1;
        d_jump      = 1'b1;
        d_imm_type  = IMM_J;
        d_wb_sel    = WB_PC4;
      end
      OPC_JALR: begin
        d_reg_write = 1'b1;
        d_jump      = 1'b1;
        d_is_jalr   = 1'b1;
        d_alu_src   = 1'b1;
        d_wb_sel    = WB_PC4;
      end
      OPC_BRANCH: begin
        d_branch_en = 1'b1;
        d_imm_type  = IMM_B;
        case (f3)
          3'b000:  d_alu_op = ALU_BEQ;
          3'b001:  d_alu_op = ALU_BNE;
          3'b100:  d_alu_op = ALU_BLT;
          3'b101:  d_alu_op = ALU_BGE;
          3'b110:  d_alu_op = ALU_BLTU;
          3'b111:  d_alu_op = ALU_BGEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d_mem_read  = 1'b1;
        d_reg_write = 1'b1;
        d_alu_src   = 1'b1;
        d_wb_sel    = WB_MEM;
        case (f3)
          3'b000:  d_mem_size = MEM_BYTE;
          3'b001:  d_mem_size = MEM_HALF;
          3'b010:  d_mem_size = MEM_WORD;
          3'b100:  d_mem_size = MEM_BYTE_U;
          3'b101:  d_mem_size = MEM_HALF_U;
          default: bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        d_mem_write = 1'b1;
        d_alu_src   = 1'b1;
        d_imm_type  = IMM_S;
        case (f3)
          3'b000:  d_mem_size = MEM_BYTE;
          3'b001:  d_mem_size = MEM_HALF;
          3'b010:  d_mem_size = MEM_WORD;
          default: bad = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        d_reg_write = 1'b1;
        d_alu_src   = 1'b1;
        case (f3)
          3'b000: d_alu_op = ALU_ADD;
          3'b001: begin
            d_alu_op = ALU_SLL;
            if (f7 != 7'h00) bad = 1'b1;
          end
          3'b010: d_alu_op = ALU_SLT;
          3'b011: d_alu_op = ALU_SLTU;
          3'b100: d_alu_op = ALU_XOR;
          3'b101: begin
            if (f7 == 7'h00)      d_alu_op = ALU_SRL;
            else if (f7 == 7'h20) d_alu_op = ALU_SRA;
            else                  bad = 1'b1;
          end
          3'b110: d_alu_op = ALU_OR;
          default: d_alu_op = ALU_AND;
        endcase
      end
      OPC_OP: begin
        case (f7)
          7'h00: begin
            d_reg_write = 1'b1;
            case (f3)
              3'b000:  d_alu_op = ALU_ADD;
              3'b001:  d_alu_op = ALU_SLL;
              3'b010:  d_alu_op = ALU_SLT;
              3'b011:  d_alu_op = ALU_SLTU;
              3'b100:  d_alu_op = ALU_XOR;
              3'b101:  d_alu_op = ALU_SRL;
              3'b110:  d_alu_op = ALU_OR;
              default: d_alu_op = ALU_AND;
            endcase
          end
          7'h20: begin
            d_reg_write = 1'b1;
            if (f3 == 3'b000)      d_alu_op = ALU_SUB;
            else if (f3 == 3'b101) d_alu_op = ALU_SRA;
            else                   bad = 1'b1;
          end
          7'h01: begin
            if (ENABLE_M != 0) begin
              d_reg_write = 1'b1;
              d_m_valid   = 1'b1;
              d_wb_sel    = WB_MEXT;
              case (f3)
                3'b000:  d_m_op = M_MUL;
                3'b001:  d_m_op = M_MULH;
                3'b010:  d_m_op = M_MULHSU;
                3'b011:  d_m_op = M_MULHU;
                3'b100:  d_m_op = M_DIV;
                3'b101:  d_m_op = M_DIVU;
                3'b110:  d_m_op = M_REM;
                default: d_m_op = M_REMU;
              endcase
            end else begin
              bad = 1'b1;
            end
          end
          default: bad = 1'b1;
        endcase
      end
      OPC_FENCE: begin
        d_illegal = 1'b0;
      end
      OPC_SYSTEM: begin
        // Only ECALL and EBREAK are accepted, as NOPs.
        if (!(instr == 32'h0000_0073 || instr == 32'h0010_0073)) bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      d_reg_write = 1'b0;
      d_mem_read  = 1'b0;
      d_mem_write = 1'b0;
      d_alu_src   = 1'b0;
      d_branch_en = 1'b0;
      d_jump      = 1'b0;
      d_is_jalr   = 1'b0;
      d_m_valid   = 1'b0;
      d_alu_op    = ALU_ADD;
      d_wb_sel    = WB_ALU;
      d_imm_type  = IMM_I;
      d_mem_size  = MEM_WORD;
      d_m_op      = M_MUL;
      d_illegal   = 1'b1;
    end
  end

  logic uses_rs1, uses_rs2, hazard, accept, bump;

  // Load-use interlock: the held load's rd feeds a source of the offered word.
  always_comb begin
    uses_rs1 = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
    uses_rs2 = (opc == OPC_BRANCH || opc == OPC_STORE || opc == OPC_OP);
    hazard   = (LOAD_USE_STALL != 0) && dec_valid && mem_read && (rd != 5'd0) &&
               ((uses_rs1 && instr[19:15] == rd) || (uses_rs2 && instr[24:20] == rd));
  end

  assign instr_ready = !flush && !hazard && (!dec_valid || dec_ready);
  assign accept      = instr_valid && instr_ready;
  // A bubble is counted only when a real word was held back by the interlock.
  assign bump        = !flush && hazard && dec_ready && instr_valid;

  // Output bundle register: flush empties it, accept replaces it, a
  // drained bundle leaves an empty slot with the side-effect controls cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_valid <= 1'b0;
      rd        <= 5'd0;
      rs1       <= 5'd0;
      rs2       <= 5'd0;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      alu_src   <= 1'b0;
      branch_en <= 1'b0;
      jump      <= 1'b0;
      is_jalr   <= 1'b0;
      m_valid   <= 1'b0;
      illegal   <= 1'b0;
      alu_op    <= ALU_ADD;
      wb_sel    <= WB_ALU;
      imm_type  <= IMM_I;
      mem_size  <= MEM_WORD;
      m_op      <= M_MUL;
    end else if (accept) begin
      dec_valid <= 1'b1;
      rd        <= instr[11:7];
      rs1       <= instr[19:15];
      rs2       <= instr[24:20];
      reg_write <= d_reg_write;
      mem_read  <= d_mem_read;
      mem_write <= d_mem_write;
      alu_src   <= d_alu_src;
      branch_en <= d_branch_en;
      jump      <= d_jump;
      is_jalr   <= d_is_jalr;
      m_valid   <= d_m_valid;
      illegal   <= d_illegal;
      alu_op    <= d_alu_op;
      wb_sel    <= d_wb_sel;
      imm_type  <= d_imm_type;
      mem_size  <= d_mem_size;
      m_op      <= d_m_op;
    end else if (flush || dec_ready) begin
      dec_valid <= 1'b0;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      alu_src   <= 1'b0;
      branch_en <= 1'b0;
      jump      <= 1'b0;
      is_jalr   <= 1'b0;
      m_valid   <= 1'b0;
      illegal   <= 1'b0;
    end
  end

  // Saturating count of load-use bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (bump && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
